// File: rtl/clk_divider_multi_if.sv
// Divisor programming bus for clk_divider_multi.
// Carries the write strobe, target channel and value, and returns the reject pulse.
interface clk_divider_multi_if #(
   parameter int N_CH  = 4,
   parameter int CTR_W = 27
);
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             div_wr;
   logic [SEL_W-1:0] div_sel;
   logic [CTR_W-1:0] div_value;
   logic             div_err;

   modport master (
      output div_wr, div_sel, div_value,
      input  div_err
   );

   modport slave (
      input  div_wr, div_sel, div_value,
      output div_err
   );
endinterface

// File: rtl/clk_divider_multi.sv
// N-channel programmable clock divider / tick generator.
// Divisors change only at period boundaries, so no runt pulses.
module clk_divider_multi #(
   parameter int N_CH        = 4,
   parameter int CTR_W       = 27,
   parameter int DEFAULT_DIV = 100_000
) (
   input  logic                incoming_CLK100MHZ,
   input  logic                reset,
   input  logic [N_CH-1:0]     enable,
   input  logic                sync,
   clk_divider_multi_if.slave  cfg,
   output logic [N_CH-1:0]     outgoing_CLK,
   output logic [N_CH-1:0]     tick
);
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int SEL_N = 1 << SEL_W;
   localparam logic [CTR_W-1:0] DEF = CTR_W'(DEFAULT_DIV);

   logic [CTR_W-1:0] ctr_q  [N_CH];
   logic [CTR_W-1:0] act_q  [N_CH];
   logic [CTR_W-1:0] pend_q [N_CH];
   logic [CTR_W-1:0] ctr_d  [N_CH];
   logic [CTR_W-1:0] act_d  [N_CH];
   logic [CTR_W-1:0] pend_d [N_CH];
   logic [CTR_W-1:0] half   [N_CH];

   logic [SEL_N-1:0] sel_in_range;
   logic [N_CH-1:0]  wr_hit;
   logic [N_CH-1:0]  run;
   logic [N_CH-1:0]  last;
   logic [N_CH-1:0]  clk_d;
   logic [N_CH-1:0]  tick_d;
   logic             wr_ok;
   logic             wr_bad;
   logic             err_q;

   // Which select codes name a real channel (matters for non-power-of-two N_CH)
   always_comb begin
      for (int i = 0; i < SEL_N; i++) begin
         sel_in_range[i] = (i < N_CH);
      end
   end

   // Write validation: divisor of at least 2 and an existing channel
   always_comb begin
      wr_ok  = cfg.div_wr
               && sel_in_range[cfg.div_sel]
               && (cfg.div_value >= CTR_W'(2));
      wr_bad = cfg.div_wr && !wr_ok;
   end

   // Per-channel next state: sync, park, wrap or count; outputs from next count
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         wr_hit[k] = wr_ok && (cfg.div_sel == SEL_W'(k));
         run[k]    = enable[k] || (ctr_q[k] != '0);
         last[k]   = (ctr_q[k] == act_q[k] - CTR_W'(1));
         pend_d[k] = wr_hit[k] ? cfg.div_value : pend_q[k];
         ctr_d[k]  = ctr_q[k];
         act_d[k]  = act_q[k];
         if (sync) begin
            ctr_d[k] = '0;
            act_d[k] = wr_hit[k] ? cfg.div_value : pend_q[k];
         end else if (!run[k]) begin
            act_d[k] = pend_q[k];
         end else if (last[k]) begin
            ctr_d[k] = '0;
            act_d[k] = pend_q[k];
         end else begin
            ctr_d[k] = ctr_q[k] + CTR_W'(1);
         end
         half[k]   = act_d[k] >> 1;
         clk_d[k]  = (ctr_d[k] >= half[k]);
         tick_d[k] = (ctr_d[k] == half[k]);
      end
   end

   // Channel state and registered outputs
   always_ff @(posedge incoming_CLK100MHZ or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N_CH; k++) begin
            ctr_q[k]  <= '0;
            act_q[k]  <= DEF;
            pend_q[k] <= DEF;
         end
         outgoing_CLK <= '0;
         tick         <= '0;
         err_q        <= 1'b0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            ctr_q[k]  <= ctr_d[k];
            act_q[k]  <= act_d[k];
            pend_q[k] <= pend_d[k];
         end
         outgoing_CLK <= clk_d;
         tick         <= tick_d;
         err_q        <= wr_bad;
      end
   end

   assign cfg.div_err = err_q;
endmodule

// File: tb/tb_clk_divider_multi.sv
// Testbench for clk_divider_multi: sample-queue reference model
// feeding a per-cycle scoreboard, plus directed reset/reject checks.
module tb_clk_divider_multi;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int DD = 10;

   typedef struct packed {
      logic [N-1:0] clk;
      logic [N-1:0] tk;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] enable;
   logic         sync;
   logic [N-1:0] outgoing_CLK;
   logic [N-1:0] tick;
   logic [2:0]   en3;
   logic         sync3;
   logic [2:0]   out3;
   logic [2:0]   tick3;

   int checks = 0;
   int errors = 0;

   clk_divider_multi_if #(.N_CH(N), .CTR_W(W)) cfg ();
   clk_divider_multi_if #(.N_CH(3), .CTR_W(W)) cfg3 ();

   clk_divider_multi #(.N_CH(N), .CTR_W(W), .DEFAULT_DIV(DD)) u_dut (
      .incoming_CLK100MHZ (clk),
      .reset              (reset),
      .enable             (enable),
      .sync               (sync),
      .cfg                (cfg),
      .outgoing_CLK       (outgoing_CLK),
      .tick               (tick)
   );

   clk_divider_multi #(.N_CH(3), .CTR_W(W), .DEFAULT_DIV(DD)) u_dut3 (
      .incoming_CLK100MHZ (clk),
      .reset              (reset),
      .enable             (en3),
      .sync               (sync3),
      .cfg                (cfg3),
      .outgoing_CLK       (out3),
      .tick               (tick3)
   );

   always #5 clk = ~clk;

   // Reference model: each running period is a queue of (out,tick) samples
   int   m_act  [N];
   int   m_pend [N];
   bit   m_zero [N];
   int   q      [N][$];
   exp_t sb [$];

   function automatic int mctr(int k);
      if (m_zero[k]) return 0;
      return m_act[k] - 1 - q[k].size();
   endfunction

   always @(posedge clk) begin
      exp_t e;
      bit   valid;
      int   s;
      e = '0;
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            m_act[k] = DD;
            m_pend[k] = DD;
            m_zero[k] = 1'b1;
            q[k].delete();
         end
      end else begin
         valid = cfg.div_wr && (int'(cfg.div_value) >= 2);
         e.err = cfg.div_wr && !valid;
         for (int k = 0; k < N; k++) begin
            bit hit;
            hit = valid && (int'(cfg.div_sel) == k);
            s = 0;
            if (sync) begin
               q[k].delete();
               m_zero[k] = 1'b1;
               if (hit) m_pend[k] = int'(cfg.div_value);
               m_act[k] = m_pend[k];
            end else begin
               if (m_zero[k]) begin
                  if (enable[k]) begin
                     for (int c = 1; c < m_act[k]; c++)
                        q[k].push_back({int'(c >= m_act[k] / 2), 1'b0}
                                       | int'(c == m_act[k] / 2));
                     s = q[k].pop_front();
                     m_zero[k] = 1'b0;
                  end else begin
                     m_act[k] = m_pend[k];
                  end
               end else if (q[k].size() > 0) begin
                  s = q[k].pop_front();
               end else begin
                  m_zero[k] = 1'b1;
                  m_act[k] = m_pend[k];
               end
               if (hit) m_pend[k] = int'(cfg.div_value);
            end
            e.clk[k] = s[1];
            e.tk[k]  = s[0];
         end
      end
      sb.push_back(e);
   end

   // Monitor: compare every presented output cycle against the model
   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = '{clk: outgoing_CLK, tk: tick, err: cfg.div_err};
         checks++;
         if (a !== e) begin
            errors++;
            if (errors <= 30)
               $display("FAIL cycle t=%0t: got clk=%b tick=%b err=%b, want clk=%b tick=%b err=%b",
                        $time, a.clk, a.tk, a.err, e.clk, e.tk, e.err);
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(int sel, int val);
      cfg.div_wr = 1'b1;
      cfg.div_sel = 2'(sel);
      cfg.div_value = W'(val);
      cyc(1);
      cfg.div_wr = 1'b0;
   endtask

   task automatic wait_ctr(int k, int v);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (mctr(k) == v) found = 1'b1;
         else cyc(1);
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL wait_ctr ch%0d: ctr %0d never reached", k, v);
      end
   endtask

   task automatic chk(string name, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   initial begin
      reset = 1'b1;
      enable = '1;
      sync = 1'b0;
      cfg.div_wr = 1'b0;
      cfg.div_sel = '0;
      cfg.div_value = '0;
      en3 = '1;
      sync3 = 1'b0;
      cfg3.div_wr = 1'b0;
      cfg3.div_sel = '0;
      cfg3.div_value = '0;
      #1;
      chk("reset_clk", int'(outgoing_CLK), 0);
      chk("reset_tick", int'(tick), 0);
      cyc(2);
      reset = 1'b0;
      cyc(25);

      wait_ctr(0, 2);
      wr(0, 4);
      cyc(25);

      wr(1, 3);
      cyc(12);
      wr(1, 2);
      cyc(10);

      wr(2, 1);
      wr(2, 0);
      cyc(3);
      cfg3.div_wr = 1'b1;
      cfg3.div_sel = 2'd3;
      cfg3.div_value = W'(5);
      cyc(1);
      cfg3.div_wr = 1'b0;
      chk("err_sel_range", int'(cfg3.div_err), 1);
      cyc(1);
      chk("err_one_cycle", int'(cfg3.div_err), 0);
      cfg3.div_wr = 1'b1;
      cfg3.div_sel = 2'd2;
      cyc(1);
      cfg3.div_wr = 1'b0;
      chk("err_valid_sel", int'(cfg3.div_err), 0);

      wait_ctr(2, 7);
      enable[2] = 1'b0;
      cyc(15);
      enable[2] = 1'b1;
      cyc(15);

      wr(1, 7);
      wr(0, 5);
      cyc(13);
      sync = 1'b1;
      cfg.div_wr = 1'b1;
      cfg.div_sel = 2'd3;
      cfg.div_value = W'(6);
      cyc(1);
      sync = 1'b0;
      cfg.div_wr = 1'b0;
      cyc(15);

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 19) == 0)
            enable[$urandom_range(0, N-1)] ^= 1'b1;
         cfg.div_wr = ($urandom_range(0, 9) == 0);
         cfg.div_sel = 2'($urandom_range(0, N-1));
         cfg.div_value = W'($urandom_range(0, 12));
         sync = ($urandom_range(0, 59) == 0);
         cyc(1);
      end
      cfg.div_wr = 1'b0;
      sync = 1'b0;
      enable = '1;
      cyc(20);

      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("midrun_reset_clk", int'(outgoing_CLK), 0);
      chk("midrun_reset_tick", int'(tick), 0);
      cyc(2);
      reset = 1'b0;
      cyc(30);

      @(negedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
